// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, widths and helpers for the fifo enqueue arbiter
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Width of the WAIT-cycle counter; comfortably covers any practical TIMEOUT.
    localparam int WCNT_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_enque_arbiter_if.sv
// rtl/fifo_enque_arbiter_if.sv - producer and fifo-side signals of the enqueue arbiter
interface fifo_enque_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           enque;
    logic [W-1:0]   enque_data;
    logic           enqued;
    logic           is_full;
    logic           busy;
    logic           timeout_err;

    modport slave (
        input  req, req_data, enqued, is_full,
        output ack, enque, enque_data, busy, timeout_err
    );

    modport master (
        output req, req_data, enqued, is_full,
        input  ack, enque, enque_data, busy, timeout_err
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin winner selection starting at ptr
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [PW:0]   rsum;
    logic [PW:0]   usum;
    logic [PW-1:0] off;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then map back.
    // Wrapping is done by comparing against N so non-power-of-2 N works.
    always_comb begin
        rot    = '0;
        rsum   = '0;
        usum   = '0;
        off    = '0;
        any    = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            rsum = {1'b0, ptr} + (PW+1)'(k);
            if (rsum >= (PW+1)'(N)) begin
                rsum = rsum - (PW+1)'(N);
            end
            rot[k] = req[rsum[PW-1:0]];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PW'(k);
                any = 1'b1;
            end
        end
        usum = {1'b0, ptr} + {1'b0, off};
        if (usum >= (PW+1)'(N)) begin
            usum = usum - (PW+1)'(N);
        end
        winner = usum[PW-1:0];
    end

endmodule

// File: rtl/fifo_enque_arbiter.sv
// rtl/fifo_enque_arbiter.sv - round-robin sharing of one fifo enqueue port among N producers
module fifo_enque_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fifo_enque_arbiter_if.slave  bus
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    next_ptr;
    logic             any;
    logic [WCNT_W-1:0] wcnt;
    logic [W-1:0]     win_data;

    fifo_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // Data word of the current round-robin winner.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == PW'(i)) begin
                win_data = bus.req_data[i*W +: W];
            end
        end
    end

    // Pointer moves just past the producer being retired, wrapping at N-1.
    assign next_ptr = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);

    // Grant / issue / wait sequencer; every output is a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            sel             <= '0;
            wcnt            <= '0;
            bus.enque       <= 1'b0;
            bus.enque_data  <= '0;
            bus.ack         <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    if (any && !bus.is_full) begin
                        sel            <= winner;
                        bus.enque_data <= win_data;
                        bus.enque      <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.enque <= 1'b0;
                    wcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (bus.enqued) begin
                        bus.ack[sel] <= 1'b1;
                        ptr          <= next_ptr;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        bus.timeout_err <= 1'b1;
                        ptr             <= next_ptr;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                default: begin
                    bus.enque <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
